ram_sp_param: RTL and testbench

Parametrised single-port synchronous RAM with per-byte write enables, a registered read port with a valid strobe, and a hardware clear sequencer that zeroes the whole array after reset, one word per cycle. It is the next-generation storage block for the memory model: width and depth are generic, and optional parity detects corrupted words. Users gate traffic on `busy` and consume read data on `rvalid`.

---
 rtl/ram_sp_param.sv | 154 +++++++++++++++
 tb/tb_ram_sp_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM with byte enables, registered read + valid strobe,
// and a post-reset clear sequencer. Define RAM_PARITY_EN for per-byte even parity.
module ram_sp_param #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 10,
  localparam int BE_W   = DATA_W / 8,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              perr
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                clear_we;

  logic                acc_ok, rd_fire, wr_fire;
  logic [BE_W-1:0]     mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [BE_W-1:0][7:0] mem [DEPTH];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (state_q == ST_CLEAR);
    clear_we = (state_q == ST_CLEAR);
  end

  // A request coinciding with reset is not accepted; that also kills any read
  // that would otherwise complete in the cycle after reset.
  always_comb begin
    acc_ok    = req && !busy && !rst;
    rd_fire   = acc_ok && !wren;
    wr_fire   = acc_ok && wren;
    rvalid_d  = rd_fire;
    mem_we    = '0;
    mem_addr  = addr;
    mem_wdata = wdata;
    if (clear_we && !rst) begin
      mem_we    = '1;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][i] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; the output register carries the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_fire) begin
      rdata_q <= mem[addr];
    end
  end

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] wpar;
  logic [BE_W-1:0] rpar_calc;
  logic [BE_W-1:0] par_rd_q;
  logic [BE_W-1:0] par_mem [DEPTH];

  // Clear data is all-zero, so its computed parity is zero as well.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_par
    assign wpar[gi]      = ^mem_wdata[8*gi +: 8];
    assign rpar_calc[gi] = ^rdata_q[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (mem_we[i]) begin
        par_mem[mem_addr][i] <= wpar[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_rd_q <= '0;
    end else if (rd_fire) begin
      par_rd_q <= par_mem[addr];
    end
  end

  assign perr = rvalid_q && (|(rpar_calc ^ par_rd_q));
`else
  assign perr = 1'b0;
`endif

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param (DATA_W=32, ADDR_W=4) with a cycle-level
// reference model; the parity section is built only with RAM_PARITY_EN.
module tb_ram_sp_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wren = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    be = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          perr;

  int checks = 0;
  int errors = 0;

  ram_sp_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .wren(wren), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words as plain array, clear modelled as a countdown.
  logic [DW-1:0] m_mem [DEPTH];
  logic [3:0]    m_bad [DEPTH];
  int            clear_left = 0;
  bit            m_live = 0;
  logic          e_rvalid = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_perr = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_live     = 1;
      clear_left = DEPTH;
      e_rvalid   = 1'b0;
      e_rdata    = '0;
      e_perr     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_bad[i] = '0;
      end
    end else if (m_live) begin
      e_rvalid = 1'b0;
      if (clear_left > 0) begin
        clear_left = clear_left - 1;
      end else if (req) begin
        if (!wren) begin
          e_rvalid = 1'b1;
          e_rdata  = m_mem[addr];
          e_perr   = |m_bad[addr];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
              m_mem[addr][8*b +: 8] = wdata[8*b +: 8];
              m_bad[addr][b]        = 1'b0;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("cyc_busy", 32'(busy), 32'(clear_left > 0));
      chk("cyc_rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("cyc_rdata", rdata, e_rdata);
      if (e_rvalid) chk("cyc_perr", 32'(perr), 32'(e_perr));
    end
  end

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
    req = 1'b1; wren = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; wren = 1'b0;
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    req = 1'b1; wren = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({name, "_rdata"}, rdata, exp);
  endtask

  // Releases reset and counts edges until busy falls; optional traffic is
  // presented during the clear and must be dropped.
  task automatic release_and_count(output int n, output bit saw_rv);
    n = 0;
    saw_rv = 0;
    rst = 1'b0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
      if (rvalid) saw_rv = 1;
    end
    req = 1'b0; wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_perr", 32'(perr), 32'd0);

    // Clear with a write then a read presented while busy.
    req = 1'b1; wren = 1'b1; addr = 4'd2; wdata = 32'h12345678; be = 4'hF;
    fork
      begin
        repeat (4) @(negedge clk);
        wren = 1'b0;
      end
    join_none
    release_and_count(n, saw);
    chk("clear_len", 32'(n), 32'd16);
    chk("clear_no_rvalid", 32'(saw), 32'd0);
    chk("ready_busy", 32'(busy), 32'd0);
    for (int a = 0; a < DEPTH; a++) read_chk(AW'(a), 32'h0, "clear_word");
    read_chk(4'd2, 32'h0, "busy_drop");

    write(4'd5, 32'hAABBCCDD, 4'hF);
    write(4'd5, 32'h11223344, 4'b0101);
    write(4'd5, 32'h99999999, 4'b0000);
    read_chk(4'd5, 32'hAA22CC44, "be_merge");

    // Write, then two reads at full rate.
    req = 1'b1; wren = 1'b1; addr = 4'd3; wdata = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    wren = 1'b0; addr = 4'd3;
    @(negedge clk);
    addr = 4'd4;
    chk("b2b_rv1", 32'(rvalid), 32'd1);
    chk("b2b_d1", rdata, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_rv2", 32'(rvalid), 32'd1);
    chk("b2b_d2", rdata, 32'h0);
    @(negedge clk);
    chk("rv_single", 32'(rvalid), 32'd0);
    chk("rdata_hold", rdata, 32'h0);

    for (int a = 0; a < DEPTH; a++) write(AW'(a), 32'hFFFFFFFF, 4'hF);
    read_chk(4'd9, 32'hFFFFFFFF, "fill");

    // A read presented together with reset must not complete.
    req = 1'b1; wren = 1'b0; addr = 4'd9; rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("rst_kill_rv", 32'(rvalid), 32'd0);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    chk("midclr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    release_and_count(n, saw);
    chk("reclear_len", 32'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) read_chk(AW'(a), 32'h0, "reclear_word");

    write(4'd7, 32'h000000FF, 4'hF);
`ifdef RAM_PARITY_EN
    dut.mem[7][0][0] = ~dut.mem[7][0][0];
    m_mem[7][0] = ~m_mem[7][0];
    m_bad[7][0] = 1'b1;
    read_chk(4'd7, 32'h000000FE, "par_data");
    chk("par_perr", 32'(perr), 32'd1);
    write(4'd7, 32'h000000FF, 4'b0001);
    read_chk(4'd7, 32'h000000FF, "par_fix");
    chk("par_fix_perr", 32'(perr), 32'd0);
`else
    read_chk(4'd7, 32'h000000FF, "nopar_data");
    chk("nopar_perr", 32'(perr), 32'd0);
`endif
    @(negedge clk);
    chk("final_perr_idle", 32'(perr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
